color_identify_seq: RTL

//  Identify-mode sequencer for the TCS3200-style colour sensor, upstream of the filter-select mux.
//  - Drives filter_select_identify through red, green and blue in turn.
//  - Counts sensor_out rising edges over a fixed gate window per filter.
//  - Publishes the three counts plus a dominant-colour decision each frame.
//  - Runs only while ready=1, i.e. after white balance is complete.

---
 rtl/color_identify_seq_if.sv | 36 +++
 rtl/color_identify_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/color_identify_seq_if.sv
// Signal bundle between the identify-mode sequencer and its environment.
// The slave modport is the sequencer's view; master is the driving side.
interface color_identify_seq_if #(
  parameter int unsigned CNT_W = 16
);
  logic             ready;
  logic             sensor_out;
  logic [1:0]       filter_select_identify;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] g_count;
  logic [CNT_W-1:0] b_count;
  logic [1:0]       color_id;
  logic             color_valid;

  modport master (
    output ready,
    output sensor_out,
    input  filter_select_identify,
    input  r_count,
    input  g_count,
    input  b_count,
    input  color_id,
    input  color_valid
  );

  modport slave (
    input  ready,
    input  sensor_out,
    output filter_select_identify,
    output r_count,
    output g_count,
    output b_count,
    output color_id,
    output color_valid
  );
endinterface

// File: rtl/color_identify_seq.sv
// Identify-mode sequencer: steps the colour filter R->G->B, counts sensor edges over a fixed
// gate per filter, then publishes the three counts and a dominant-colour decision each frame.
module color_identify_seq #(
  parameter int unsigned GATE_CYCLES   = 100000,
  parameter int unsigned SETTLE_CYCLES = 1000,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned MIN_COUNT     = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  color_identify_seq_if.slave seq_io
);

  localparam int unsigned TimerMax = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TimerW   = (TimerMax > 2) ? $clog2(TimerMax) : 1;

  localparam logic [TimerW-1:0] GateLast   = TimerW'(GATE_CYCLES - 1);
  localparam logic [TimerW-1:0] SettleLast = TimerW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CntMax     = '1;
  localparam logic [CNT_W-1:0]  MinCnt     = CNT_W'(MIN_COUNT);

  localparam logic [1:0] FiltRed   = 2'b00;
  localparam logic [1:0] FiltGreen = 2'b11;
  localparam logic [1:0] FiltBlue  = 2'b01;

  typedef enum logic [1:0] {StIdle, StSettle, StGate, StDecide} state_e;
  typedef enum logic [1:0] {ChRed, ChGreen, ChBlue} ch_e;

  state_e            state_q, state_d;
  ch_e               ch_q, ch_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]  r_sh_q, r_sh_d;
  logic [CNT_W-1:0]  g_sh_q, g_sh_d;
  logic [1:0]        filter_q, filter_d;
  logic [CNT_W-1:0]  r_cnt_q, r_cnt_d;
  logic [CNT_W-1:0]  g_cnt_q, g_cnt_d;
  logic [CNT_W-1:0]  b_cnt_q, b_cnt_d;
  logic [1:0]        color_id_q, color_id_d;
  logic              valid_q, valid_d;

  logic              sync1_q, sync2_q, sync3_q;
  logic              edge_det;
  logic [CNT_W-1:0]  cnt_inc;

  // Winner must beat both others strictly and reach the minimum count.
  function automatic logic [1:0] pick_color(input logic [CNT_W-1:0] r,
                                            input logic [CNT_W-1:0] g,
                                            input logic [CNT_W-1:0] b);
    logic [1:0] id;
    id = 2'd0;
    if (r > g && r > b && r >= MinCnt) begin
      id = 2'd1;
    end else if (g > r && g > b && g >= MinCnt) begin
      id = 2'd2;
    end else if (b > r && b > g && b >= MinCnt) begin
      id = 2'd3;
    end
    return id;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= seq_io.sensor_out;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign edge_det = sync2_q & ~sync3_q;
  assign cnt_inc  = (edge_det && edge_cnt_q != CntMax) ? edge_cnt_q + 1'b1 : edge_cnt_q;

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    timer_d    = timer_q;
    edge_cnt_d = edge_cnt_q;
    r_sh_d     = r_sh_q;
    g_sh_d     = g_sh_q;
    filter_d   = filter_q;
    r_cnt_d    = r_cnt_q;
    g_cnt_d    = g_cnt_q;
    b_cnt_d    = b_cnt_q;
    color_id_d = color_id_q;
    valid_d    = 1'b0;

    // Losing ready abandons the frame; published results are left untouched.
    if (state_q != StIdle && !seq_io.ready) begin
      state_d    = StIdle;
      ch_d       = ChRed;
      timer_d    = '0;
      edge_cnt_d = '0;
      r_sh_d     = '0;
      g_sh_d     = '0;
      filter_d   = FiltRed;
    end else begin
      unique case (state_q)
        StIdle: begin
          filter_d = FiltRed;
          if (seq_io.ready) begin
            state_d    = StSettle;
            ch_d       = ChRed;
            timer_d    = '0;
            edge_cnt_d = '0;
          end
        end
        StSettle: begin
          if (timer_q == SettleLast) begin
            state_d = StGate;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        StGate: begin
          edge_cnt_d = cnt_inc;
          if (timer_q == GateLast) begin
            timer_d    = '0;
            edge_cnt_d = '0;
            case (ch_q)
              ChRed: begin
                r_sh_d   = cnt_inc;
                ch_d     = ChGreen;
                filter_d = FiltGreen;
                state_d  = StSettle;
              end
              ChGreen: begin
                g_sh_d   = cnt_inc;
                ch_d     = ChBlue;
                filter_d = FiltBlue;
                state_d  = StSettle;
              end
              default: begin
                // Blue count goes straight to the outputs so all three publish in DECIDE.
                state_d    = StDecide;
                r_cnt_d    = r_sh_q;
                g_cnt_d    = g_sh_q;
                b_cnt_d    = cnt_inc;
                color_id_d = pick_color(r_sh_q, g_sh_q, cnt_inc);
                valid_d    = 1'b1;
              end
            endcase
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        StDecide: begin
          state_d  = StSettle;
          ch_d     = ChRed;
          timer_d  = '0;
          filter_d = FiltRed;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ch_q       <= ChRed;
      timer_q    <= '0;
      edge_cnt_q <= '0;
      r_sh_q     <= '0;
      g_sh_q     <= '0;
      filter_q   <= FiltRed;
      r_cnt_q    <= '0;
      g_cnt_q    <= '0;
      b_cnt_q    <= '0;
      color_id_q <= 2'd0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      timer_q    <= timer_d;
      edge_cnt_q <= edge_cnt_d;
      r_sh_q     <= r_sh_d;
      g_sh_q     <= g_sh_d;
      filter_q   <= filter_d;
      r_cnt_q    <= r_cnt_d;
      g_cnt_q    <= g_cnt_d;
      b_cnt_q    <= b_cnt_d;
      color_id_q <= color_id_d;
      valid_q    <= valid_d;
    end
  end

  assign seq_io.filter_select_identify = filter_q;
  assign seq_io.r_count                = r_cnt_q;
  assign seq_io.g_count                = g_cnt_q;
  assign seq_io.b_count                = b_cnt_q;
  assign seq_io.color_id               = color_id_q;
  assign seq_io.color_valid            = valid_q;

endmodule
